// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller feeding the output 2:1 mux.
// Define CACHE_STATS_EN to add saturating 8-bit read hit/miss counters (hit_cnt, miss_cnt).
module cache_ctrl #(
    parameter int DATA_W  = 3,
    parameter int ADDR_W  = 6,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] cache_rdata,
    output logic [DATA_W-1:0] fill_data,
    output logic              mux_sel,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [7:0]        hit_cnt,
    output logic [7:0]        miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        WR_REQ,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [DATA_W-1:0]  data_arr [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               accept;
    logic               rd_hit;
    logic               rd_miss;
    logic               wr_hit;
    logic               fill;
    logic               wr_done;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];
    assign hit = valid_q[idx] && (tag_arr[idx] == tag);

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        accept        = 1'b0;
        rd_hit        = 1'b0;
        rd_miss       = 1'b0;
        wr_hit        = 1'b0;
        fill          = 1'b0;
        wr_done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    wr_hit    = hit;
                    state_nxt = WR_REQ;
                end else if (hit) begin
                    rd_hit    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    rd_miss   = 1'b1;
                    state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                if (mem_req_ready) state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    fill      = 1'b1;
                    state_nxt = RESP;
                end
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                if (mem_req_ready) begin
                    wr_done   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            valid_q     <= '0;
            cache_rdata <= '0;
            fill_data   <= '0;
            mux_sel     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (rd_hit) begin
                cache_rdata <= data_arr[idx];
                mux_sel     <= 1'b0;
            end
            if (fill) begin
                fill_data    <= mem_rdata;
                valid_q[idx] <= 1'b1;
                mux_sel      <= 1'b1;
            end
            if (wr_done) begin
                cache_rdata <= '0;
                mux_sel     <= 1'b0;
            end
        end
    end

    // Tag/data storage carries no reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (wr_hit) data_arr[idx] <= wdata_q;
        if (fill) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (rd_hit && hit_cnt != 8'hFF)    hit_cnt  <= hit_cnt + 8'd1;
            if (rd_miss && miss_cnt != 8'hFF)  miss_cnt <= miss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expectations, a monitor checks each response.
// A small memory model handles the memory port and checks request stability.
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [5:0] req_addr = '0;
    logic [2:0] req_wdata = '0;
    logic       resp_valid;
    logic [2:0] cache_rdata;
    logic [2:0] fill_data;
    logic       mux_sel;
    logic       mem_req_valid;
    logic       mem_req_ready = 1'b0;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [2:0] mem_wdata;
    logic       mem_resp_valid = 1'b0;
    logic [2:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;
`endif

    cache_ctrl #(.DATA_W(3), .ADDR_W(6), .INDEX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .cache_rdata(cache_rdata), .fill_data(fill_data),
        .mux_sel(mux_sel),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] data;
        logic       sel;
        int         mem_reqs;
        int         mem_start;
        int         lat;
        int         req_cyc;
    } exp_t;
    exp_t sb[$];

    // ---------------- memory model ----------------
    logic [2:0] mem_model [64];
    int         hold_cycles = 0;
    int         wait_left = 0;
    bit         stall = 1'b0;
    bit         pend = 1'b0;
    bit         resp_next = 1'b0;
    logic [5:0] resp_addr = '0;
    logic [5:0] prev_addr;
    logic       prev_we;
    logic [2:0] prev_wdata;
    logic [5:0] exp_mem_addr = '0;
    logic       exp_mem_we = 1'b0;
    int         mem_cnt = 0;

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (resp_next) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_model[resp_addr];
            resp_next      = 1'b0;
        end
        if (rst_n && mem_req_valid) begin
            if (pend) begin
                chk("mem_addr_stable", int'(mem_addr), int'(prev_addr));
                chk("mem_we_stable", int'(mem_we), int'(prev_we));
                chk("mem_wdata_stable", int'(mem_wdata), int'(prev_wdata));
            end else begin
                chk("mem_addr", int'(mem_addr), int'(exp_mem_addr));
                chk("mem_we", int'(mem_we), int'(exp_mem_we));
                prev_addr  = mem_addr;
                prev_we    = mem_we;
                prev_wdata = mem_wdata;
                pend       = 1'b1;
                wait_left  = hold_cycles;
            end
            if (wait_left > 0) begin
                mem_req_ready = 1'b0;
                wait_left--;
            end else begin
                mem_req_ready = 1'b1;
                mem_cnt++;
                pend = 1'b0;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else if (!stall) begin
                    resp_next = 1'b1;
                    resp_addr = mem_addr;
                end
            end
        end else begin
            mem_req_ready = 1'b0;
            pend          = 1'b0;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mux_sel", int'(mux_sel), int'(e.sel));
                chk("mux_out", int'(mux_sel ? fill_data : cache_rdata), int'(e.data));
                chk("mem_req_count", mem_cnt - e.mem_start, e.mem_reqs);
                if (e.lat >= 0) chk("hit_latency", cyc - e.req_cyc, e.lat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int b = 0;
        while (!req_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic do_req(input logic we, input logic [5:0] addr, input logic [2:0] wdata,
                          input int hold, input logic exp_sel, input logic [2:0] exp_data,
                          input int exp_mem, input int exp_lat);
        exp_t e;
        @(negedge clk);
        wait_idle();
        hold_cycles  = hold;
        exp_mem_addr = addr;
        exp_mem_we   = we;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        e.sel        = exp_sel;
        e.data       = exp_data;
        e.mem_reqs   = exp_mem;
        e.mem_start  = mem_cnt;
        e.lat        = exp_lat;
        e.req_cyc    = cyc;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_resp_valid"}, int'(resp_valid), 0);
        chk({tag, "_mux_sel"}, int'(mux_sel), 0);
        chk({tag, "_mem_req_valid"}, int'(mem_req_valid), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_fill_data"}, int'(fill_data), 0);
        chk({tag, "_cache_rdata"}, int'(cache_rdata), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    endtask

    initial begin
        int start;
        int b;
        for (int i = 0; i < 64; i++) mem_model[i] = 3'b000;
        mem_model[5]  = 3'b101;
        mem_model[9]  = 3'b011;
        mem_model[10] = 3'b110;
        mem_model[1]  = 3'b001;

        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 6'h05, 3'b000, 0, 1'b1, 3'b101, 1, -1);  // cold miss, fill path
        do_req(1'b0, 6'h05, 3'b000, 0, 1'b0, 3'b101, 0, 2);   // hit, 2-cycle latency
        do_req(1'b1, 6'h05, 3'b010, 3, 1'b0, 3'b000, 1, -1);  // write hit, stalled memory
        do_req(1'b0, 6'h05, 3'b000, 0, 1'b0, 3'b010, 0, 2);   // read-after-write hit
        do_req(1'b0, 6'h09, 3'b000, 1, 1'b1, 3'b011, 1, -1);  // conflict miss evicts 0x05
        do_req(1'b0, 6'h05, 3'b000, 0, 1'b1, 3'b010, 1, -1);  // 0x05 misses again
        do_req(1'b1, 6'h0A, 3'b111, 0, 1'b0, 3'b000, 1, -1);  // write miss, no allocate
        do_req(1'b0, 6'h0A, 3'b000, 0, 1'b1, 3'b111, 1, -1);  // still a miss
        do_req(1'b0, 6'h05, 3'b000, 0, 1'b0, 3'b010, 0, 2);   // line 1 holds 0x05

        // Abandon a read in MISS_WAIT by asserting reset; memory never answers it.
        stall = 1'b1;
        @(negedge clk);
        hold_cycles  = 0;
        exp_mem_addr = 6'h01;
        exp_mem_we   = 1'b0;
        start        = mem_cnt;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 6'h01;
        @(negedge clk);
        req_valid = 1'b0;
        b = 0;
        while (mem_cnt == start && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("abandon_mem_issued", mem_cnt - start, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_resp_after_rst", sb.size(), 0);

        do_req(1'b0, 6'h05, 3'b000, 0, 1'b1, 3'b010, 1, -1);  // invalidated by reset

        b = 0;
        while (sb.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller; sits directly upstream of the cache output 2:1 mux.
- Drives the mux's din_0 (cache array read data), din_1 (captured memory fill data) and sel (0 = hit path, 1 = fill path).
- Handshakes with the CPU on one side and a single-outstanding memory port on the other.

Parameters:
DATA_W, 3, data word width; matches the output mux width.
ADDR_W, 6, CPU/memory word address width.
INDEX_W, 2, line index bits; 2**INDEX_W one-word lines; tag width = ADDR_W-INDEX_W.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request valid
req_ready  output  1  controller accepts request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  one-cycle response pulse
cache_rdata  output  DATA_W  array data, to mux din_0
fill_data  output  DATA_W  registered memory read data, to mux din_1
mux_sel  output  1  mux select: 0 hit, 1 fill
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_resp_valid  input  1  memory read data valid (reads only)
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; all valid bits 0; req_ready=1, resp_valid=0, mux_sel=0, mem_req_valid=0, mem_we=0, fill_data=0, cache_rdata=0, mem_addr=0, mem_wdata=0. Tag/data arrays are not reset.
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WR_REQ, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/we/wdata and go to LOOKUP. req_ready=0 in every other state; one request in flight at a time.
- LOOKUP: hit = valid[idx] && tag[idx]==addr tag.
  - Read hit: cache_rdata <= data[idx], mux_sel <= 0, go to RESP. Request to response = 2 cycles.
  - Read miss: go to MISS_REQ.
  - Write, hit or miss: if hit, data[idx] <= wdata (tag/valid unchanged). A write miss does not allocate. Go to WR_REQ.
- MISS_REQ: mem_req_valid=1, mem_we=0, mem_addr=latched addr. On mem_req_ready, go to MISS_WAIT.
- MISS_WAIT: on mem_resp_valid, fill_data <= mem_rdata, data[idx] <= mem_rdata, tag[idx] <= tag, valid[idx] <= 1, mux_sel <= 1, go to RESP.
- WR_REQ: mem_req_valid=1, mem_we=1, mem_wdata=latched wdata. On mem_req_ready, mux_sel <= 0, cache_rdata <= 0, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. mux_sel, cache_rdata and fill_data hold until the next update.
- mem_req_valid stays high with stable mem_addr/mem_we/mem_wdata until mem_req_ready. mem_resp_valid outside MISS_WAIT is ignored.
- Back-to-back: a new req_valid may be accepted in the first IDLE cycle after RESP.
- Read after a write to the same line hits and returns the new data.
- Reset mid-transaction: the transaction is abandoned; no response is issued; all lines become invalid.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_cnt and miss_cnt, 8 bits each, reset to 0. Increment in LOOKUP on read hit and read miss respectively; writes are not counted. Saturate at 255.
- Undefined: these ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset, then read addr 0x05 with memory returning 3'b101 -> MISS_REQ then MISS_WAIT; resp_valid pulses once; mux_sel=1; fill_data=3'b101.
- Read 0x05 again -> resp_valid 2 cycles after acceptance; mux_sel=0; cache_rdata=3'b101; no mem_req_valid.
- Write 0x05 data 3'b010, holding mem_req_ready low 3 cycles -> mem_req_valid and mem_wdata stable throughout; then read 0x05 -> hit; cache_rdata=3'b010.
- Read 0x09 (same index as 0x05, different tag) -> miss and refill; a following read of 0x05 misses.
- Write 0x0A with no prior read -> memory write issued; a following read of 0x0A misses (no allocate).
- Assert rst_n low during MISS_WAIT -> outputs return to reset values immediately; no resp_valid; a following read of 0x05 misses.
